txheaderbit: RTL

- Transmit-side counterpart of the receive header path: builds the 18-bit BR packet header (LT_ADDR, TYPE, FLOW, ARQN, SEQN, HEC).
- Whitens the header, applies FEC 1/3 repetition, and serialises 54 bits at one bit per p_1us onto txbit.
- Sits between the TX packet controller (fields, start pulse) and the modulator bit stream.
- Hands the live whitening LFSR state to the TX payload serialiser.

---
 rtl/txheaderbit_pkg.sv | 20 ++
 rtl/txheaderbit_hec.sv | 32 +++
 rtl/txheaderbit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/txheaderbit_pkg.sv
// Shared constants and FSM encoding for the BR transmit header path.
// Polynomials here must match the receive-side header checker.
package txheaderbit_pkg;

    localparam int HDR_BITS      = 18;
    localparam int FEC_REP       = 3;
    localparam int HEC_DATA_BITS = 10;

    // x^8+x^7+x^5+x^2+x+1, x^8 term implied by the shift
    localparam logic [7:0] HEC_POLY = 8'hA7;
    // x^7+x^4+1: feedback of w[6] lands on bit 4 and wraps into bit 0
    localparam logic [6:0] WHIT_TAP = 7'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/txheaderbit_hec.sv
// Serial 8-bit HEC generator: seeded with the UAP, advanced once per
// unencoded data bit, then held while its contents are shifted out.
module txhec_lfsr
    import txheaderbit_pkg::*;
(
    input  logic       clk_6M,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_en,
    input  logic       i_freeze,
    input  logic       i_din,
    output logic [7:0] o_hec
);

    logic [7:0] r_hec;
    logic       w_fb;

    assign w_fb  = r_hec[7] ^ i_din;
    assign o_hec = r_hec;

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_hec <= 8'h00;
        end else if (i_load) begin
            r_hec <= i_seed;
        end else if (i_en && !i_freeze) begin
            r_hec <= {r_hec[6:0], 1'b0} ^ (w_fb ? HEC_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/txheaderbit.sv
// BR header transmitter: builds the 18-bit header with HEC, whitens it,
// repeats each bit three times and serialises one bit per p_1us interval.
module txheaderbit
    import txheaderbit_pkg::*;
(
    input  logic       clk_6M,
    input  logic       rst,
    input  logic       p_1us,
    input  logic       header_st_p,
    input  logic       tx_abort_p,
    input  logic       regi_txwhitening,
    input  logic [7:0] hec_uap,
    input  logic [2:0] lt_addr,
    input  logic [3:0] pk_type,
    input  logic       flow,
    input  logic       arqn,
    input  logic       seqn,
    input  logic [5:0] clk6_1,
    output logic       txbit,
    output logic       header_en,
    output logic       py_st_p,
    output logic [6:0] whitening,
    output logic       busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rep_cnt;
    logic [4:0]  r_bit_cnt;
    logic [9:0]  r_data;
    logic [6:0]  r_whit;
    logic        r_txbit;
    logic        r_header_en;
    logic        r_py_st_p;

    logic        w_start;
    logic        w_last_rep;
    logic        w_last_bit;
    logic        w_launch;
    logic        w_end;
    logic [4:0]  w_nidx;
    logic [2:0]  w_hec_idx;
    logic [15:0] w_data_ext;
    logic        w_is_data;
    logic        w_raw;
    logic        w_coded;
    logic [6:0]  w_whit_nxt;
    logic [7:0]  w_hec;

    assign w_start    = (r_state == IDLE) && header_st_p && !tx_abort_p;
    assign w_last_rep = (r_rep_cnt == 2'(FEC_REP - 1));
    assign w_last_bit = (r_bit_cnt == 5'(HDR_BITS - 1));

    // A new unencoded bit goes out on the first p_1us after ARM, and on
    // every p_1us that closes the third repetition of a non-final bit.
    assign w_launch = !tx_abort_p && p_1us &&
                      ((r_state == ARM) ||
                       ((r_state == SEND) && w_last_rep && !w_last_bit));
    assign w_end    = !tx_abort_p && p_1us && (r_state == SEND) &&
                      w_last_rep && w_last_bit;

    assign w_nidx     = (r_state == ARM) ? 5'd0 : (r_bit_cnt + 5'd1);
    assign w_hec_idx  = 3'(5'(HDR_BITS - 1) - w_nidx);
    assign w_data_ext = {6'b0, r_data};
    assign w_is_data  = (w_nidx < 5'(HEC_DATA_BITS));
    assign w_raw      = w_is_data ? w_data_ext[w_nidx[3:0]] : w_hec[w_hec_idx];
    assign w_coded    = w_raw ^ (regi_txwhitening & r_whit[6]);
    assign w_whit_nxt = {r_whit[5:0], r_whit[6]} ^ (r_whit[6] ? WHIT_TAP : 7'h00);

    txhec_lfsr u_hec (
        .clk_6M   (clk_6M),
        .rst      (rst),
        .i_load   (w_start),
        .i_seed   (hec_uap),
        .i_en     (w_launch),
        .i_freeze (!w_is_data),
        .i_din    (w_raw),
        .o_hec    (w_hec)
    );

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (tx_abort_p) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (header_st_p) w_state_nxt = ARM;
                ARM:     if (p_1us)       w_state_nxt = SEND;
                SEND:    if (w_end)       w_state_nxt = IDLE;
                default:                  w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_rep_cnt   <= 2'd0;
            r_bit_cnt   <= 5'd0;
            r_data      <= 10'd0;
            r_whit      <= 7'h00;
            r_txbit     <= 1'b0;
            r_header_en <= 1'b0;
            r_py_st_p   <= 1'b0;
        end else begin
            r_py_st_p <= 1'b0;
            if (tx_abort_p) begin
                r_txbit     <= 1'b0;
                r_header_en <= 1'b0;
                r_rep_cnt   <= 2'd0;
                r_bit_cnt   <= 5'd0;
            end else begin
                if (w_start) begin
                    r_data <= {seqn, arqn, flow, pk_type, lt_addr};
                    r_whit <= {1'b1, clk6_1};
                end
                if (w_launch) begin
                    r_txbit     <= w_coded;
                    r_header_en <= 1'b1;
                    r_whit      <= w_whit_nxt;
                    r_rep_cnt   <= 2'd0;
                    r_bit_cnt   <= w_nidx;
                end else if (w_end) begin
                    r_txbit     <= 1'b0;
                    r_header_en <= 1'b0;
                    r_py_st_p   <= 1'b1;
                    r_rep_cnt   <= 2'd0;
                    r_bit_cnt   <= 5'd0;
                end else if ((r_state == SEND) && p_1us) begin
                    r_rep_cnt <= r_rep_cnt + 2'd1;
                end
            end
        end
    end

    assign txbit     = r_txbit;
    assign header_en = r_header_en;
    assign py_st_p   = r_py_st_p;
    assign whitening = r_whit;
    assign busy      = (r_state != IDLE);

endmodule
